controller_input_sampler: RTL and testbench
===========================================

# controller_input_sampler

Samples the two raw Pong controller button sets and produces the two 16-bit controller words that the memory-mapped BRAM wrapper writes to 0xC001 and 0xC002. It sits directly upstream of that wrapper's `cont_1`/`cont_2` inputs. Each button goes through three steps: a synchroniser, a debouncer, and a sticky press flag that the CPU read clears. The CPU therefore sees both held levels and presses that happened between polls.

## Interface
- `NUM_BTN`, 4: buttons per controller (up, down, fire, start).
- `DEBOUNCE_CYCLES`, 50000: cycles a synchronised input must differ from the stable state before the stable state flips. Minimum 2.
- `CNT_W`, 16: debounce counter width. Must satisfy `DEBOUNCE_CYCLES` < 2^`CNT_W`.
- `REPEAT_CYCLES`, 5000000: auto-repeat period, used only with `CONT_AUTOREPEAT_EN`.
- `REPEAT_W`, 24: repeat counter width.
- `clk`  in  1  system clock. One clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `btn_1`  in  `NUM_BTN`  raw controller 1 buttons, asynchronous, active high.
- `btn_2`  in  `NUM_BTN`  raw controller 2 buttons, asynchronous, active high.
- `addr_a`  in  16  CPU port-A address, the same net that feeds the BRAM wrapper.
- `cont_1`  out  16  controller 1 word, registered.
- `cont_2`  out  16  controller 2 word, registered.

## Operation
- Word format, identical for both controllers:
  - [3:0]: debounced levels.
  - [7:4]: sticky press flags.
  - [14:8]: zero.
  - [15]: valid.
- Synchroniser: two flops per raw bit, reset to 0.
- Debouncer, per bit, with a stable state and a counter:
  - If sync == stable: counter is cleared.
  - Else, if counter == `DEBOUNCE_CYCLES`-1: stable <= sync and counter <= 0.
  - Else: counter increments.
  - A glitch shorter than `DEBOUNCE_CYCLES` never changes the stable state.
- Press event: the stable state goes 0→1. A press sets the matching sticky flag. Release (1→0) changes only the level bit.
- Clear:
  - At any clock edge with `addr_a` == 0xC001, all sticky flags of `cont_1` clear. 0xC002 does the same for `cont_2`.
  - Because the wrapper captures `cont_x` combinationally in that same cycle, the CPU observes the flags before they clear.
  - Press and clear on the same edge: the set wins and the flag stays 1.
  - Other addresses have no effect. Consecutive cycles at 0xC001 keep the flags clear.
- Valid:
  - A shared counter runs after reset.
  - Bit 15 rises after `DEBOUNCE_CYCLES` cycles, then stays 1 until the next reset.
  - Until then, bits [7:0] are forced to 0 so power-up chatter produces no press events.
- Reset:
  - `cont_1`, `cont_2`, all sync flops, stable states, counters, sticky flags and the valid bit go to 0.
  - Reset asserted mid-debounce discards the partial count.

## Timing
- Raw change held steady → level bit updates exactly 2 + `DEBOUNCE_CYCLES` edges later.
- Sticky flag sets on the same edge as the level bit.
- Clear: the flag reads 0 on the cycle after the edge where `addr_a` matched.
- Both outputs come straight from registers, with no combinational path from inputs.
- All eight buttons are independent. Simultaneous events on different bits do not interact.

## Configuration
- `CONT_AUTOREPEAT_EN` defined:
  - Each button has a repeat counter, which counts while the stable state is 1 and is cleared when the stable state is 0.
  - When it reaches `REPEAT_CYCLES`-1, the sticky flag sets again and the counter restarts.
  - The first repeat occurs `REPEAT_CYCLES` cycles after the press edge.
- Not defined: only the 0→1 edge sets flags. No repeat counters are built.

## Structure
- Package `cont_pkg` holds:
  - Button indices: `BTN_UP`=0, `BTN_DOWN`=1, `BTN_FIRE`=2, `BTN_START`=3.
  - `CONT1_ADDR`=16'hC001 and `CONT2_ADDR`=16'hC002. The BRAM wrapper uses the same constants.
  - Field positions: `LVL_LSB`=0, `FLAG_LSB`=4, `VALID_BIT`=15.
- Sub-module `btn_debounce`, one instance per button (8 total):
  - Contains the synchroniser, debounce counter and stable state, plus the optional repeat counter.
  - Outputs: level and a one-cycle press pulse.
- The top level owns the sticky flags, the clear decode, the valid counter and output assembly.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `REPEAT_CYCLES`=10.
- Reset, then idle 10 cycles → outputs 0x0000 while reset is held, then 0x8000 from 4 cycles after reset release.
- `btn_1`[0] rises and holds → `cont_1` = 0x8011 exactly 6 edges later. Release → 0x8010 after 6 more edges.
- `btn_2`[2] pulses for 3 cycles → `cont_2` stays 0x8000 (glitch rejected).
- With `cont_1`=0x8011, drive `addr_a`=0xC001 for 1 cycle → next cycle 0x8001. `addr_a`=0xC002 leaves `cont_1` unchanged.
- Press edge coincides with `addr_a`=0xC001 → flag reads 1 afterwards (set wins).
- `CONT_AUTOREPEAT_EN` build: hold `btn_1`[1], clear flags every cycle after the press → bit 5 reasserts 10 cycles after the press edge. Non-macro build: bit 5 never reasserts.

Source files
------------

// File: rtl/controller_input_sampler_pkg.sv
// Shared constants for the controller sampler: button indices, CPU addresses and word field positions.
// The BRAM wrapper imports the same addresses so decode and storage never disagree.
package cont_pkg;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_FIRE  = 2;
  localparam int BTN_START = 3;

  localparam logic [15:0] CONT1_ADDR = 16'hC001;
  localparam logic [15:0] CONT2_ADDR = 16'hC002;

  localparam int LVL_LSB   = 0;
  localparam int FLAG_LSB  = 4;
  localparam int VALID_BIT = 15;
endpackage

// File: rtl/controller_input_sampler_if.sv
// Button/address/controller-word bundle between the board-side driver and the sampler.
// The sampler uses the slave modport; whatever drives buttons and the CPU address uses master.
interface controller_input_sampler_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_1;
  logic [NUM_BTN-1:0] btn_2;
  logic [15:0]        addr_a;
  logic [15:0]        cont_1;
  logic [15:0]        cont_2;

  modport master (output btn_1, output btn_2, output addr_a, input cont_1, input cont_2);
  modport slave  (input btn_1, input btn_2, input addr_a, output cont_1, output cont_2);
endinterface

// File: rtl/controller_input_sampler_btn_debounce.sv
// One button: 2-flop synchroniser, debounce counter/stable state, press pulse; level_d_o is next stable state.
// CONT_AUTOREPEAT_EN adds a repeat counter that re-pulses press_o while the button stays held.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int REPEAT_W        = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_d_o,
  output logic press_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;
  logic             rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    flip     = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        flip     = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Exported pre-register so the top's output word flips on the same edge as the stable state.
  assign level_d_o = stable_d;
  assign rise      = flip & sync2_q;

`ifdef CONT_AUTOREPEAT_EN
  localparam logic [REPEAT_W-1:0] REP_LAST = REPEAT_W'(REPEAT_CYCLES - 1);

  logic [REPEAT_W-1:0] rep_q, rep_d;
  logic                rep_fire;

  always_ff @(posedge clk) begin
    if (reset) rep_q <= '0;
    else       rep_q <= rep_d;
  end

  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (stable_q) begin
      if (rep_q == REP_LAST) rep_fire = 1'b1;
      else                   rep_d    = rep_q + 1'b1;
    end
  end

  assign press_o = rise | rep_fire;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_CYCLES > 0) && (REPEAT_W > 0);
  assign press_o = rise;
`endif
endmodule

// File: rtl/controller_input_sampler.sv
// Two controllers x NUM_BTN buttons -> registered 16-bit words {valid, 0, sticky flags, levels}.
// Flags clear on a CPU access to CONT1_ADDR/CONT2_ADDR (press wins); CONT_AUTOREPEAT_EN enables held-button repeat.
import cont_pkg::*;

module controller_input_sampler #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int REPEAT_W        = 24
) (
  input logic                       clk,
  input logic                       reset,
  controller_input_sampler_if.slave bus
);
  localparam logic [CNT_W-1:0] VALID_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0][NUM_BTN-1:0] raw;
  logic [1:0][NUM_BTN-1:0] lvl_d;
  logic [1:0][NUM_BTN-1:0] press;
  logic [1:0][NUM_BTN-1:0] flags_d;
  logic [1:0][15:0]        cont_q, cont_d;
  logic [1:0]              clr;

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;

  assign raw[0] = bus.btn_1;
  assign raw[1] = bus.btn_2;
  assign clr[0] = (bus.addr_a == CONT1_ADDR);
  assign clr[1] = (bus.addr_a == CONT2_ADDR);

  for (genvar c = 0; c < 2; c++) begin : g_cont
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .REPEAT_CYCLES  (REPEAT_CYCLES),
        .REPEAT_W       (REPEAT_W)
      ) u_btn (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (raw[c][i]),
        .level_d_o(lvl_d[c][i]),
        .press_o  (press[c][i])
      );
    end
  end

  // Power-up hold-off: one shared counter, valid latches and stays until reset.
  always_comb begin
    valid_d = valid_q;
    vcnt_d  = vcnt_q;
    if (!valid_q) begin
      if (vcnt_q == VALID_LAST) valid_d = 1'b1;
      else                      vcnt_d  = vcnt_q + 1'b1;
    end
  end

  always_comb begin
    flags_d = '0;
    cont_d  = '0;
    for (int c = 0; c < 2; c++) begin
      flags_d[c] = (clr[c] ? '0 : cont_q[c][FLAG_LSB +: NUM_BTN]) | press[c];
      if (valid_d) begin
        cont_d[c][VALID_BIT]          = 1'b1;
        cont_d[c][LVL_LSB +: NUM_BTN] = lvl_d[c];
        cont_d[c][FLAG_LSB +: NUM_BTN] = flags_d[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      vcnt_q  <= '0;
      cont_q  <= '0;
    end else begin
      valid_q <= valid_d;
      vcnt_q  <= vcnt_d;
      cont_q  <= cont_d;
    end
  end

  assign bus.cont_1 = cont_q[0];
  assign bus.cont_2 = cont_q[1];
endmodule

// File: tb/tb_controller_input_sampler.sv
// Directed bench for controller_input_sampler with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
// Expected repeat behaviour follows CONT_AUTOREPEAT_EN as the RTL is built.
module tb_controller_input_sampler;
  import cont_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  controller_input_sampler_if #(.NUM_BTN(4)) bus ();

  controller_input_sampler #(
    .NUM_BTN        (4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16),
    .REPEAT_CYCLES  (10),
    .REPEAT_W       (24)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.btn_1 = '0;
    bus.btn_2 = '0;
    bus.addr_a = '0;
    tick(3);
    tests++; if (bus.cont_1 !== 16'h0000) begin fails++; $display("FAIL reset_c1 got %h want %h", bus.cont_1, 16'h0000); end
    tests++; if (bus.cont_2 !== 16'h0000) begin fails++; $display("FAIL reset_c2 got %h want %h", bus.cont_2, 16'h0000); end
    reset = 1'b0;
    tick(3);
    tests++; if (bus.cont_1 !== 16'h0000) begin fails++; $display("FAIL prevalid_c1 got %h want %h", bus.cont_1, 16'h0000); end
    tick(1);
    tests++; if (bus.cont_1 !== 16'h8000) begin fails++; $display("FAIL valid_c1 got %h want %h", bus.cont_1, 16'h8000); end
    tests++; if (bus.cont_2 !== 16'h8000) begin fails++; $display("FAIL valid_c2 got %h want %h", bus.cont_2, 16'h8000); end
    tick(6);
    tests++; if (bus.cont_1 !== 16'h8000) begin fails++; $display("FAIL idle_c1 got %h want %h", bus.cont_1, 16'h8000); end
  endtask

  task automatic test_press_release();
    bus.btn_1[BTN_UP] = 1'b1;
    tick(5);
    tests++; if (bus.cont_1 !== 16'h8000) begin fails++; $display("FAIL press_early got %h want %h", bus.cont_1, 16'h8000); end
    tick(1);
    tests++; if (bus.cont_1 !== 16'h8011) begin fails++; $display("FAIL press_edge got %h want %h", bus.cont_1, 16'h8011); end
    bus.btn_1[BTN_UP] = 1'b0;
    tick(5);
    tests++; if (bus.cont_1 !== 16'h8011) begin fails++; $display("FAIL release_early got %h want %h", bus.cont_1, 16'h8011); end
    tick(1);
    tests++; if (bus.cont_1 !== 16'h8010) begin fails++; $display("FAIL release_edge got %h want %h", bus.cont_1, 16'h8010); end
  endtask

  task automatic test_glitch();
    bus.btn_2[BTN_FIRE] = 1'b1;
    tick(3);
    bus.btn_2[BTN_FIRE] = 1'b0;
    tick(10);
    tests++; if (bus.cont_2 !== 16'h8000) begin fails++; $display("FAIL glitch_c2 got %h want %h", bus.cont_2, 16'h8000); end
  endtask

  task automatic test_clear();
    bus.btn_1[BTN_UP] = 1'b1;
    tick(6);
    tests++; if (bus.cont_1 !== 16'h8011) begin fails++; $display("FAIL clear_setup got %h want %h", bus.cont_1, 16'h8011); end
    bus.addr_a = CONT2_ADDR;
    tick(1);
    bus.addr_a = 16'h0000;
    tests++; if (bus.cont_1 !== 16'h8011) begin fails++; $display("FAIL clear_other_addr got %h want %h", bus.cont_1, 16'h8011); end
    bus.addr_a = CONT1_ADDR;
    #1;
    tests++; if (bus.cont_1 !== 16'h8011) begin fails++; $display("FAIL clear_visible got %h want %h", bus.cont_1, 16'h8011); end
    tick(1);
    bus.addr_a = 16'h0000;
    tests++; if (bus.cont_1 !== 16'h8001) begin fails++; $display("FAIL clear_c1 got %h want %h", bus.cont_1, 16'h8001); end
    bus.addr_a = CONT1_ADDR;
    tick(3);
    bus.addr_a = 16'h0000;
    tests++; if (bus.cont_1 !== 16'h8001) begin fails++; $display("FAIL clear_repeat got %h want %h", bus.cont_1, 16'h8001); end
  endtask

  task automatic test_set_wins();
    bus.btn_1[BTN_UP] = 1'b0;
    tick(6);
    tests++; if (bus.cont_1 !== 16'h8000) begin fails++; $display("FAIL setwins_setup got %h want %h", bus.cont_1, 16'h8000); end
    bus.btn_1[BTN_UP] = 1'b1;
    tick(5);
    bus.addr_a = CONT1_ADDR;
    tick(1);
    bus.addr_a = 16'h0000;
    tests++; if (bus.cont_1 !== 16'h8011) begin fails++; $display("FAIL set_wins got %h want %h", bus.cont_1, 16'h8011); end
  endtask

  task automatic test_independent();
    bus.btn_1[BTN_START] = 1'b1;
    bus.btn_2[BTN_DOWN]  = 1'b1;
    tick(6);
    tests++; if (bus.cont_1 !== 16'h8099) begin fails++; $display("FAIL indep_c1 got %h want %h", bus.cont_1, 16'h8099); end
    tests++; if (bus.cont_2 !== 16'h8022) begin fails++; $display("FAIL indep_c2 got %h want %h", bus.cont_2, 16'h8022); end
    bus.btn_1 = '0;
    bus.btn_2 = '0;
    tick(6);
    tests++; if (bus.cont_1 !== 16'h8090) begin fails++; $display("FAIL indep_rel_c1 got %h want %h", bus.cont_1, 16'h8090); end
    tests++; if (bus.cont_2 !== 16'h8020) begin fails++; $display("FAIL indep_rel_c2 got %h want %h", bus.cont_2, 16'h8020); end
    bus.addr_a = CONT1_ADDR;
    tick(1);
    tests++; if (bus.cont_2 !== 16'h8020) begin fails++; $display("FAIL indep_c2_kept got %h want %h", bus.cont_2, 16'h8020); end
    bus.addr_a = CONT2_ADDR;
    tick(1);
    bus.addr_a = 16'h0000;
    tests++; if (bus.cont_1 !== 16'h8000) begin fails++; $display("FAIL indep_clr_c1 got %h want %h", bus.cont_1, 16'h8000); end
    tests++; if (bus.cont_2 !== 16'h8000) begin fails++; $display("FAIL indep_clr_c2 got %h want %h", bus.cont_2, 16'h8000); end
  endtask

  task automatic test_autorepeat();
    logic [15:0] exp;
    bit          rep_en;
`ifdef CONT_AUTOREPEAT_EN
    rep_en = 1'b1;
`else
    rep_en = 1'b0;
`endif
    bus.btn_1[BTN_DOWN] = 1'b1;
    tick(6);
    tests++; if (bus.cont_1 !== 16'h8022) begin fails++; $display("FAIL rep_press got %h want %h", bus.cont_1, 16'h8022); end
    bus.addr_a = CONT1_ADDR;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      exp = (rep_en && k == 10) ? 16'h8022 : 16'h8002;
      tests++; if (bus.cont_1 !== exp) begin fails++; $display("FAIL repeat_k%0d got %h want %h", k, bus.cont_1, exp); end
    end
    bus.addr_a = 16'h0000;
  endtask

  task automatic test_reset_mid_debounce();
    bus.btn_2[BTN_UP] = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);
    tests++; if (bus.cont_1 !== 16'h0000) begin fails++; $display("FAIL midrst_c1 got %h want %h", bus.cont_1, 16'h0000); end
    tests++; if (bus.cont_2 !== 16'h0000) begin fails++; $display("FAIL midrst_c2 got %h want %h", bus.cont_2, 16'h0000); end
    reset = 1'b0;
    tick(5);
    tests++; if (bus.cont_2 !== 16'h8000) begin fails++; $display("FAIL midrst_early_c2 got %h want %h", bus.cont_2, 16'h8000); end
    tests++; if (bus.cont_1 !== 16'h8000) begin fails++; $display("FAIL midrst_early_c1 got %h want %h", bus.cont_1, 16'h8000); end
    tick(1);
    tests++; if (bus.cont_2 !== 16'h8011) begin fails++; $display("FAIL midrst_c2_press got %h want %h", bus.cont_2, 16'h8011); end
    tests++; if (bus.cont_1 !== 16'h8022) begin fails++; $display("FAIL midrst_c1_press got %h want %h", bus.cont_1, 16'h8022); end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_clear();
    test_set_wins();
    test_independent();
    test_autorepeat();
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
